mul_result_stage: RTL and testbench



---
 rtl/mul_result_stage.sv | 181 ++++++++++++++++++
 tb/tb_mul_result_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_result_stage                                              |
// | Description : Response stage behind the iterative signed multiplier.        |
// |               Captures request sideband at issue, applies the MULHU/MULHSU  |
// |               high-half corrections to the signed x signed product, selects |
// |               the low/high word per lane and drives an elastic valid/ready  |
// |               output toward commit.                                         |
// |               Optional macro MUL_RESULT_OUTREG_EN: when defined, results    |
// |               pass through a 2-entry registered skid FIFO (1-cycle latency, |
// |               mul_ready from registered state only). When undefined, the    |
// |               stage is a 0-latency combinational pass-through.              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mul_result_stage #(
    parameter int LANES     = 1,
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_fire,
    input  logic [1:0]                issue_op,
    input  logic [TAG_WIDTH-1:0]      issue_tag,
    input  logic [LANES*XLEN-1:0]     issue_dataa,
    input  logic [LANES*XLEN-1:0]     issue_datab,
    input  logic                      mul_valid,
    output logic                      mul_ready,
    input  logic [LANES*2*XLEN-1:0]   mul_result,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic [LANES*XLEN-1:0]     out_data
);

    localparam logic [1:0] c_OP_MUL    = 2'd0;
    localparam logic [1:0] c_OP_MULH   = 2'd1;
    localparam logic [1:0] c_OP_MULHSU = 2'd2;
    localparam logic [1:0] c_OP_MULHU  = 2'd3;

    // Sideband captured at issue, consumed when the product arrives
    logic [1:0]            r_op;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [LANES*XLEN-1:0] r_dataa;
    logic [LANES*XLEN-1:0] r_datab;
    logic                  r_pending;

    logic                  w_mul_hs;
    logic [LANES*XLEN-1:0] w_res_data;

    assign w_mul_hs = mul_valid && mul_ready;

    // Sideband register: issue wins over a same-cycle handshake so back-to-back
    // requests keep pending set; the handshake itself uses the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= c_OP_MUL;
            r_tag     <= '0;
            r_dataa   <= '0;
            r_datab   <= '0;
            r_pending <= 1'b0;
        end else if (issue_fire) begin
            r_op      <= issue_op;
            r_tag     <= issue_tag;
            r_dataa   <= issue_dataa;
            r_datab   <= issue_datab;
            r_pending <= 1'b1;
        end else if (w_mul_hs) begin
            r_pending <= 1'b0;
        end
    end

    // Per-lane result selection. The multiplier always treats both operands as
    // signed; unsigned interpretations are recovered on the high word by adding
    // back the other operand whenever a sign bit was really a magnitude bit.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [XLEN-1:0] w_a;
        logic [XLEN-1:0] w_b;
        logic [XLEN-1:0] w_hi;
        logic [XLEN-1:0] w_lo;
        logic [XLEN-1:0] w_corr_b;
        logic [XLEN-1:0] w_corr_a;
        logic [XLEN-1:0] w_res;

        assign w_a      = r_dataa[g*XLEN +: XLEN];
        assign w_b      = r_datab[g*XLEN +: XLEN];
        assign w_lo     = mul_result[g*2*XLEN +: XLEN];
        assign w_hi     = mul_result[g*2*XLEN+XLEN +: XLEN];
        // b treated unsigned: add a when b's top bit was negative weight
        assign w_corr_b = w_b[XLEN-1] ? w_a : '0;
        // a treated unsigned: add b when a's top bit was negative weight
        assign w_corr_a = w_a[XLEN-1] ? w_b : '0;

        // Select low/high word and apply the op-specific correction mod 2^XLEN
        always_comb begin
            w_res = w_lo;
            case (r_op)
                c_OP_MUL:    w_res = w_lo;
                c_OP_MULH:   w_res = w_hi;
                c_OP_MULHSU: w_res = w_hi + w_corr_b;
                c_OP_MULHU:  w_res = w_hi + w_corr_b + w_corr_a;
                default:     w_res = w_lo;
            endcase
        end

        assign w_res_data[g*XLEN +: XLEN] = w_res;
    end

`ifdef MUL_RESULT_OUTREG_EN

    localparam int c_ENTRY_W = TAG_WIDTH + LANES*XLEN;

    logic [c_ENTRY_W-1:0] r_mem [0:1];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    assign w_full    = (r_count == 2'd2);
    assign w_empty   = (r_count == 2'd0);
    // Stray products (no pending request) complete the handshake but are dropped
    assign w_push    = w_mul_hs && r_pending;
    assign w_pop     = valid_out && ready_out;

    assign mul_ready = !w_full;
    assign valid_out = !w_empty;
    assign out_tag   = r_mem[r_rptr][c_ENTRY_W-1 -: TAG_WIDTH];
    assign out_data  = r_mem[r_rptr][LANES*XLEN-1:0];

    // Two-entry skid FIFO; entries are cleared on reset so idle outputs read zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {r_tag, w_res_data};
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`else

    // Pass-through: the consumer's ready flows straight back to the multiplier;
    // stray products (no pending request) are always accepted and discarded.
    assign valid_out = mul_valid && r_pending;
    assign mul_ready = ready_out || !r_pending;
    assign out_tag   = r_tag;
    assign out_data  = w_res_data;

`endif

`ifndef SYNTHESIS
    // A product must only arrive for a request whose sideband is held
    a_product_without_request : assert property (
        @(posedge clk) disable iff (reset) mul_valid |-> r_pending
    );

    // A new request must not overwrite a sideband still waiting for its product
    a_issue_overwrites_pending : assert property (
        @(posedge clk) disable iff (reset) (issue_fire && r_pending) |-> w_mul_hs
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_result_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_result_stage                                           |
// | Description : Scoreboard bench for mul_result_stage: directed vectors with  |
// |               hand-computed results, backpressure ordering and mid-flight   |
// |               reset. Follows MUL_RESULT_OUTREG_EN like the design.          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mul_result_stage;

    localparam int LANES     = 1;
    localparam int XLEN      = 32;
    localparam int TAG_WIDTH = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    issue_fire;
    logic [1:0]              issue_op;
    logic [TAG_WIDTH-1:0]    issue_tag;
    logic [LANES*XLEN-1:0]   issue_dataa;
    logic [LANES*XLEN-1:0]   issue_datab;
    logic                    mul_valid;
    logic                    mul_ready;
    logic [LANES*2*XLEN-1:0] mul_result;
    logic                    valid_out;
    logic                    ready_out;
    logic [TAG_WIDTH-1:0]    out_tag;
    logic [LANES*XLEN-1:0]   out_data;

    mul_result_stage #(
        .LANES     (LANES),
        .XLEN      (XLEN),
        .TAG_WIDTH (TAG_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_fire  (issue_fire),
        .issue_op    (issue_op),
        .issue_tag   (issue_tag),
        .issue_dataa (issue_dataa),
        .issue_datab (issue_datab),
        .mul_valid   (mul_valid),
        .mul_ready   (mul_ready),
        .mul_result  (mul_result),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .out_tag     (out_tag),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]      data;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [7:0]   tag;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [63:0]  prod;
        logic [31:0]  exp;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!reset && valid_out === 1'b1 && ready_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got tag 0x%0h data 0x%0h, expected no output",
                         out_tag, out_data);
            end else begin
                e = sb.pop_front();
                check("out_tag", {56'd0, out_tag}, {56'd0, e.tag});
                check("out_data", {32'd0, out_data}, {32'd0, e.data});
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] tag,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        issue_fire  = 1'b1;
        issue_op    = op;
        issue_tag   = tag;
        issue_dataa = a;
        issue_datab = b;
        @(posedge clk); #1;
        issue_fire  = 1'b0;
    endtask

    // Multiplier presents its product; expected response enters the scoreboard
    task automatic present(input logic [7:0] tag, input logic [63:0] prod, input logic [31:0] exp);
        exp_t e;
        mul_valid  = 1'b1;
        mul_result = prod;
        e.tag      = tag;
        e.data     = exp;
        sb.push_back(e);
`ifndef MUL_RESULT_OUTREG_EN
        #1;
        check("comb_valid", {63'd0, valid_out}, 64'd1);
        check("comb_data", {32'd0, out_data}, {32'd0, exp});
`endif
    endtask

    // Hold mul_valid until the stage accepts; returns #1 after the handshake edge
    task automatic wait_hs(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (mul_ready) done = 1'b1;
        end
        @(posedge clk); #1;
        mul_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: handshake timeout, mul_ready=%0b, expected 1", name, mul_ready);
        end
    endtask

    task automatic do_req(input vec_t v);
        issue(v.op, v.tag, v.a, v.b);
        present(v.tag, v.prod, v.exp);
        wait_hs("req_hs");
`ifdef MUL_RESULT_OUTREG_EN
        check("latency_valid", {63'd0, valid_out}, 64'd1);
`endif
    endtask

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 8'h11, 32'hFFFFFFFF, 32'h00000003, 64'hFFFFFFFF_FFFFFFFD, 32'hFFFFFFFD};
        vecs[1] = '{2'd1, 8'h12, 32'hFFFFFFFF, 32'h00000003, 64'hFFFFFFFF_FFFFFFFD, 32'hFFFFFFFF};
        vecs[2] = '{2'd3, 8'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 32'hFFFFFFFE};
        vecs[3] = '{2'd2, 8'h14, 32'hFFFFFFFF, 32'h80000000, 64'h00000000_80000000, 32'hFFFFFFFF};
        vecs[4] = '{2'd3, 8'h15, 32'h80000000, 32'h00000002, 64'hFFFFFFFF_00000000, 32'h00000001};
        vecs[5] = '{2'd1, 8'h16, 32'h12345678, 32'h00000010, 64'h00000001_23456780, 32'h00000001};
        vecs[6] = '{2'd0, 8'h17, 32'h12345678, 32'h00000010, 64'h00000001_23456780, 32'h23456780};
        vecs[7] = '{2'd2, 8'h18, 32'h00000005, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFB, 32'h00000004};
        vecs[8] = '{2'd3, 8'h19, 32'h00000007, 32'h00000009, 64'h00000000_0000003F, 32'h00000000};

        reset       = 1'b1;
        issue_fire  = 1'b0;
        issue_op    = 2'd0;
        issue_tag   = '0;
        issue_dataa = '0;
        issue_datab = '0;
        mul_valid   = 1'b0;
        mul_result  = '0;
        ready_out   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", {63'd0, valid_out}, 64'd0);
        check("rst_mul_ready", {63'd0, mul_ready}, 64'd1);
        check("rst_out_tag", {56'd0, out_tag}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        reset = 1'b0;

        // Directed arithmetic vectors
        foreach (vecs[i]) do_req(vecs[i]);

        // Backpressure: three requests against a stalled consumer
        repeat (3) @(posedge clk);
        #1;
        ready_out = 1'b0;
`ifdef MUL_RESULT_OUTREG_EN
        do_req('{2'd0, 8'h01, 32'd1, 32'd7, 64'd7, 32'd7});
        do_req('{2'd0, 8'h02, 32'd2, 32'd7, 64'd14, 32'd14});
        issue(2'd0, 8'h03, 32'd3, 32'd7);
        present(8'h03, 64'd21, 32'd21);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_full_ready", {63'd0, mul_ready}, 64'd0);
            check("bp_hold_tag", {56'd0, out_tag}, 64'h01);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after_pop", {63'd0, mul_ready}, 64'd1);
        wait_hs("bp_req3_hs");
`else
        issue(2'd0, 8'h01, 32'd1, 32'd7);
        present(8'h01, 64'd7, 32'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_ready", {63'd0, mul_ready}, 64'd0);
            check("bp_hold_tag", {56'd0, out_tag}, 64'h01);
            check("bp_hold_data", {32'd0, out_data}, 64'd7);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        wait_hs("bp_req1_hs");
        do_req('{2'd0, 8'h02, 32'd2, 32'd7, 64'd14, 32'd14});
        do_req('{2'd0, 8'h03, 32'd3, 32'd7, 64'd21, 32'd21});
`endif
        repeat (4) @(posedge clk);
        check("bp_drained", sb.size(), 64'd0);

        // Reset in the middle of an operation with the consumer stalled
        #1;
        ready_out = 1'b0;
        issue(2'd1, 8'h77, 32'hFFFFFFFF, 32'h00000003);
        present(8'h77, 64'hFFFFFFFF_FFFFFFFD, 32'hFFFFFFFF);
`ifdef MUL_RESULT_OUTREG_EN
        wait_hs("rst_mid_hs");
        check("rst_mid_pre_valid", {63'd0, valid_out}, 64'd1);
`else
        @(posedge clk); #1;
        mul_valid = 1'b0;
`endif
        reset      = 1'b1;
        mul_result = '0;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_valid_out", {63'd0, valid_out}, 64'd0);
        check("rst_mid_mul_ready", {63'd0, mul_ready}, 64'd1);
        ready_out = 1'b1;
        do_req('{2'd0, 8'h5A, 32'd2, 32'd21, 64'd42, 32'd42});

        repeat (5) @(posedge clk);
        check("final_drained", sb.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
